// File: rtl/parking_lane_sensor_decoder.sv
// parking_lane_sensor_decoder
// Conditions the two raw infrared beams of a single-lane gate. Each beam is
// synchronised and then debounced. A registered 8-state FSM then decodes
// the beams into one-cycle entry/exit pulses and latches the spot ID of an
// exiting vehicle.
//
// Optional feature: define PARKING_LANE_TIMEOUT_EN to enable stall recovery.
// With it, any non-idle state held for TIMEOUT_CYCLES forces HOLD and raises
// `fault`. Without it, the FSM may dwell in any state indefinitely and
// `fault` is tied low.
module parking_lane_sensor_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beam_outer,
  input  logic       beam_inner,
  input  logic [1:0] exit_spot_id,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exiting_position,
  output logic       busy,
  output logic       fault
);

  // Last count value before the filtered beam flips; comparing against it
  // makes the flip happen on the edge where the count reaches DEBOUNCE_CYCLES.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENT_O  = 3'd1,
    ENT_OI = 3'd2,
    ENT_I  = 3'd3,
    EXT_I  = 3'd4,
    EXT_IO = 3'd5,
    EXT_O  = 3'd6,
    HOLD   = 3'd7
  } state_t;

  // Saturating increment for the 8-bit debounce counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       outer_sync_p0, outer_sync_p1;
  logic       inner_sync_p0, inner_sync_p1;
  logic [7:0] outer_cnt, inner_cnt;
  logic       outer_filt, inner_filt;
  logic [1:0] beams;

  state_t     state, next_state;
  logic       entry_next, exit_next, latch_pos;
  logic       timeout_hit;

  // Two-flop synchronisers bring the asynchronous beams into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outer_sync_p0 <= 1'b0;
      outer_sync_p1 <= 1'b0;
      inner_sync_p0 <= 1'b0;
      inner_sync_p1 <= 1'b0;
    end else begin
      outer_sync_p0 <= beam_outer;
      outer_sync_p1 <= outer_sync_p0;
      inner_sync_p0 <= beam_inner;
      inner_sync_p1 <= inner_sync_p0;
    end
  end

  // Outer beam debounce: accept a new level only after it has been stable
  // for DEBOUNCE_CYCLES; any return to the filtered level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outer_cnt  <= 8'd0;
      outer_filt <= 1'b0;
    end else if (outer_sync_p1 == outer_filt) begin
      outer_cnt <= 8'd0;
    end else if (outer_cnt == DEB_LAST) begin
      outer_filt <= outer_sync_p1;
      outer_cnt  <= 8'd0;
    end else begin
      outer_cnt <= sat_inc8(outer_cnt);
    end
  end

  // Inner beam debounce: same filter as the outer beam, independent counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inner_cnt  <= 8'd0;
      inner_filt <= 1'b0;
    end else if (inner_sync_p1 == inner_filt) begin
      inner_cnt <= 8'd0;
    end else if (inner_cnt == DEB_LAST) begin
      inner_filt <= inner_sync_p1;
      inner_cnt  <= 8'd0;
    end else begin
      inner_cnt <= sat_inc8(inner_cnt);
    end
  end

  assign beams = {outer_filt, inner_filt};

`ifdef PARKING_LANE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Saturating increment for the 16-bit dwell counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] dwell_cnt;

  // dwell_cnt is 0 during the first cycle of a state, so reaching TO_LAST
  // means the state has been visible for TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state != IDLE) && (dwell_cnt == TO_LAST);

  // Dwell counter: restarts on every state change, including a timeout
  // re-entering HOLD, and counts only outside IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= 16'd0;
    end else if ((next_state != state) || timeout_hit) begin
      dwell_cnt <= 16'd0;
    end else if (state != IDLE) begin
      dwell_cnt <= sat_inc16(dwell_cnt);
    end else begin
      dwell_cnt <= 16'd0;
    end
  end

  // Fault flag: set by a timeout, cleared once HOLD releases to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (timeout_hit) begin
      fault <= 1'b1;
    end else if ((state == HOLD) && (next_state == IDLE)) begin
      fault <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  // State register, with the pulses, busy and the spot latch registered alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      entry_sensor     <= 1'b0;
      exit_sensor      <= 1'b0;
      busy             <= 1'b0;
      exiting_position <= 2'b00;
    end else begin
      state        <= next_state;
      entry_sensor <= entry_next;
      exit_sensor  <= exit_next;
      busy         <= (next_state != IDLE);
      if (latch_pos) begin
        exiting_position <= exit_spot_id;
      end
    end
  end

  // Next-state decode on the filtered pair {O, I}. A pair change that flips
  // both beams between single-blocked levels is not a valid passage step,
  // so it parks in HOLD.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        case (beams)
          2'b10:   next_state = ENT_O;
          2'b01:   next_state = EXT_I;
          2'b11:   next_state = HOLD;
          default: next_state = IDLE;
        endcase
      end
      ENT_O: begin
        case (beams)
          2'b11:   next_state = ENT_OI;
          2'b00:   next_state = IDLE;
          2'b01:   next_state = HOLD;
          default: next_state = ENT_O;
        endcase
      end
      ENT_OI: begin
        case (beams)
          2'b01:   next_state = ENT_I;
          2'b10:   next_state = ENT_O;
          2'b00:   next_state = IDLE;
          default: next_state = ENT_OI;
        endcase
      end
      ENT_I: begin
        case (beams)
          2'b00:   next_state = IDLE;
          2'b11:   next_state = ENT_OI;
          2'b10:   next_state = HOLD;
          default: next_state = ENT_I;
        endcase
      end
      EXT_I: begin
        case (beams)
          2'b11:   next_state = EXT_IO;
          2'b00:   next_state = IDLE;
          2'b10:   next_state = HOLD;
          default: next_state = EXT_I;
        endcase
      end
      EXT_IO: begin
        case (beams)
          2'b10:   next_state = EXT_O;
          2'b01:   next_state = EXT_I;
          2'b00:   next_state = IDLE;
          default: next_state = EXT_IO;
        endcase
      end
      EXT_O: begin
        case (beams)
          2'b00:   next_state = IDLE;
          2'b11:   next_state = EXT_IO;
          2'b01:   next_state = HOLD;
          default: next_state = EXT_O;
        endcase
      end
      HOLD: begin
        if (beams == 2'b00) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (timeout_hit) begin
      next_state = HOLD;
    end
  end

  // Output decode: completion pulses are issued only from states in which
  // the far beam has been reached; the spot ID is captured when an exit starts.
  always_comb begin
    entry_next = 1'b0;
    exit_next  = 1'b0;
    latch_pos  = 1'b0;
    case (state)
      ENT_OI, ENT_I: entry_next = (next_state == IDLE);
      EXT_IO, EXT_O: exit_next  = (next_state == IDLE);
      IDLE:          latch_pos  = (next_state == EXT_I);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_parking_lane_sensor_decoder.sv
// Testbench for parking_lane_sensor_decoder: directed scenarios with literal
// expectations, then randomized beam activity, all compared every cycle
// against a passage-level behavioural model.
module tb_parking_lane_sensor_decoder;

  localparam int DEB  = 4;
  localparam int TOUT = 16;
`ifdef PARKING_LANE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       beam_outer = 1'b0;
  logic       beam_inner = 1'b0;
  logic [1:0] exit_spot_id = 2'b00;
  logic       entry_sensor, exit_sensor, busy, fault;
  logic [1:0] exiting_position;

  always #5 clk = ~clk;

  parking_lane_sensor_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .beam_outer      (beam_outer),
    .beam_inner      (beam_inner),
    .exit_spot_id    (exit_spot_id),
    .entry_sensor    (entry_sensor),
    .exit_sensor     (exit_sensor),
    .exiting_position(exiting_position),
    .busy            (busy),
    .fault           (fault)
  );

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Passage-level model. dir: 0 none, 1 entering, 2 exiting, 3 hold.
  // pair is the filtered {O,I} seen while travelling; dwell counts visible
  // cycles of the current situation.
  typedef struct {
    int         dir;
    logic [1:0] pair;
    int         dwell;
    logic       ent;
    logic       ext;
    logic       flt;
    logic [1:0] pos;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] filt;
    int         run [2];
  } model_t;

  function automatic model_t model_zero();
    model_t z;
    z.dir = 0; z.pair = 2'b00; z.dwell = 0; z.ent = 1'b0; z.ext = 1'b0;
    z.flt = 1'b0; z.pos = 2'b00; z.d0 = 2'b00; z.d1 = 2'b00; z.filt = 2'b00;
    z.run[0] = 0; z.run[1] = 0;
    return z;
  endfunction

  function automatic model_t model_next(model_t m, logic [1:0] raw, logic [1:0] id);
    model_t     n;
    logic [1:0] f;
    int         nd;
    logic [1:0] np;
    bit         tmo, same;
    int         r;
    n = m; f = m.filt; nd = m.dir; np = m.pair;
    n.ent = 1'b0; n.ext = 1'b0;
    tmo = TO_EN && (m.dir != 0) && (m.dwell == TOUT);
    if (tmo) begin
      nd = 3; n.flt = 1'b1;
    end else if (m.dir == 0) begin
      if (f == 2'b10) begin nd = 1; np = f; end
      else if (f == 2'b01) begin nd = 2; np = f; n.pos = id; end
      else if (f == 2'b11) nd = 3;
    end else if (m.dir == 3) begin
      if (f == 2'b00) begin nd = 0; n.flt = 1'b0; end
    end else if (f != m.pair) begin
      if (f == 2'b00) begin
        nd = 0;
        // a passage completes only if the far beam was still blocked
        if (m.dir == 1) n.ent = m.pair[0];
        else            n.ext = m.pair[1];
      end else if ((f ^ m.pair) == 2'b11) nd = 3;
      else np = f;
    end
    same = (nd == m.dir) && ((nd == 3) || (np == m.pair));
    if (nd == 0) n.dwell = 0;
    else if (tmo || !same) n.dwell = 1;
    else n.dwell = m.dwell + 1;
    n.dir = nd; n.pair = np;
    for (int b = 0; b < 2; b++) begin
      if (m.d1[b] != m.filt[b]) begin
        r = m.run[b] + 1;
        if (r == DEB) begin n.filt[b] = m.d1[b]; r = 0; end
      end else r = 0;
      n.run[b] = r;
    end
    n.d1 = m.d0;
    n.d0 = raw;
    return n;
  endfunction

  model_t m;
  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_zero();
    else       m <= model_next(m, {beam_outer, beam_inner}, exit_spot_id);
  end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   chk_on = 1'b0;
  logic prev_pulse = 1'b0;

  // Per-cycle comparison against the model plus pulse-exclusivity rules.
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("entry_sensor", entry_sensor, m.ent);
      chk("exit_sensor", exit_sensor, m.ext);
      chk("exiting_position", exiting_position, m.pos);
      chk("busy", busy, (m.dir != 0));
      chk("fault", fault, m.flt);
      chk("pulse_exclusive", entry_sensor & exit_sensor, 0);
      chk("pulse_back_to_back", prev_pulse & (entry_sensor | exit_sensor), 0);
      prev_pulse <= entry_sensor | exit_sensor;
    end
  end

  int   n_ent = 0, n_ext = 0, n_busy = 0, n_ment = 0, n_mext = 0;
  int   last_ent_cyc = 0;
  logic busy_at_ent = 1'b0;
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      if (entry_sensor) begin
        n_ent        <= n_ent + 1;
        last_ent_cyc <= cyc;
        busy_at_ent  <= busy;
      end
      if (exit_sensor) n_ext  <= n_ext + 1;
      if (busy)        n_busy <= n_busy + 1;
      if (m.ent)       n_ment <= n_ment + 1;
      if (m.ext)       n_mext <= n_mext + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic o, input logic i);
    beam_outer = o;
    beam_inner = i;
  endtask

  int e0, x0, b0, me0, mx0, t_last;

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_entry", entry_sensor, 0);
    chk("rst_exit", exit_sensor, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_position", exiting_position, 0);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    step(5);

    // Entry: O, I, O off, I off at 10-cycle spacing.
    e0 = n_ent; x0 = n_ext; me0 = n_ment;
    drive(1, 0); step(10);
    drive(1, 1); step(10);
    drive(0, 1); step(10);
    t_last = cyc;
    drive(0, 0); step(15);
    chk("entry_count", n_ent - e0, 1);
    chk("entry_latency", last_ent_cyc - t_last, 7);
    chk("entry_busy_at_pulse", busy_at_ent, 0);
    chk("entry_no_exit", n_ext - x0, 0);
    chk("model_entry_count", n_ment - me0, 1);

    // Exit with spot 2; the ID input changes later and must not be re-latched.
    e0 = n_ent; x0 = n_ext; mx0 = n_mext;
    exit_spot_id = 2'b10;
    drive(0, 1); step(10);
    chk("exit_position_latched", exiting_position, 2);
    exit_spot_id = 2'b01;
    drive(1, 1); step(10);
    drive(1, 0); step(10);
    drive(0, 0); step(15);
    chk("exit_count", n_ext - x0, 1);
    chk("exit_no_entry", n_ent - e0, 0);
    chk("exit_position_final", exiting_position, 2);
    chk("model_exit_count", n_mext - mx0, 1);

    // Glitches of 3 cycles on the outer beam.
    e0 = n_ent; x0 = n_ext; b0 = n_busy;
    for (int g = 0; g < 5; g++) begin
      drive(1, 0); step(3);
      drive(0, 0); step(10);
    end
    chk("glitch_pulses", (n_ent - e0) + (n_ext - x0), 0);
    chk("glitch_busy_cycles", n_busy - b0, 0);

    // Reversed entry and reversed exit.
    e0 = n_ent; x0 = n_ext;
    drive(1, 0); step(10);
    drive(1, 1); step(10);
    drive(1, 0); step(10);
    chk("rev_entry_busy", busy, 1);
    drive(0, 0); step(15);
    drive(0, 1); step(10);
    drive(1, 1); step(10);
    drive(0, 1); step(10);
    drive(0, 0); step(15);
    chk("reversal_pulses", (n_ent - e0) + (n_ext - x0), 0);
    chk("reversal_idle", busy, 0);

    // Stalled vehicle on the outer beam.
    e0 = n_ent; x0 = n_ext;
    drive(1, 0); step(40);
    chk("stall_fault", fault, TO_EN ? 1 : 0);
    chk("stall_busy", busy, 1);
    drive(0, 0); step(12);
    chk("stall_release_fault", fault, 0);
    chk("stall_release_busy", busy, 0);
    chk("stall_pulses", (n_ent - e0) + (n_ext - x0), 0);

    // Asynchronous reset while in the middle of an entry.
    drive(1, 0); step(10);
    drive(1, 1); step(10);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    drive(0, 0);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_entry", entry_sensor, 0);
    chk("midrst_exit", exit_sensor, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_position", exiting_position, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    e0 = n_ent; x0 = n_ext;
    step(20);
    chk("post_reset_pulses", (n_ent - e0) + (n_ext - x0), 0);
    chk("post_reset_busy", busy, 0);

    // Randomized beam activity: held levels of 1..25 cycles.
    repeat (150) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exit_spot_id = 2'($urandom_range(0, 3));
      step($urandom_range(1, 25));
    end
    drive(0, 0);
    step(40);
    chk("random_final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
